game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Top-level game sequencer for the snake VGA design. It owns the `state` bus consumed by the pixel-colour stage and scores game events. It generates the snake move tick and the poisoning window, and drives `snake_clock` for the poisoned-snake colour effect. All outputs are registered on `clk_crystal`, so the renderer sees stable values for a whole cycle.

## Interface
- `WAIT_CYCLES`, default 50_000_000: countdown length in MAIN_WAIT before play starts.
- `STEP1`, default 25_000_000: move-tick period in MAIN_GAME1, in cycles.
- `STEP2`, default 15_000_000: move-tick period in MAIN_GAME2.
- `STEP3`, default 8_000_000: move-tick period in MAIN_GAME3.
- `LEVEL_FOOD`, default 5: foods per level needed to advance.
- `POISON_CYCLES`, default 200_000_000: poisoning duration.
- `clk_crystal`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  single-cycle pulse, debounced upstream.
- `food_eaten`  in  1  pulse: snake head entered food cell.
- `flash_eaten`  in  1  pulse: snake head entered flash cell.
- `virus_hit`  in  1  pulse: snake head entered virus cell.
- `collision`  in  1  pulse: head hit wall, obstacle or body.
- `state`  out  3  MAIN_START=0, MAIN_WAIT=1, MAIN_GAME1=2, MAIN_GAME2=3, MAIN_GAME3=4, MAIN_WIN=5, MAIN_LOSE=6.
- `move_tick`  out  1  one-cycle pulse that advances the snake.
- `poisoning`  out  1  high while the poison window is active.
- `snake_clock`  out  32  free-running play-time counter.
- `score`  out  10  binary score, 0..999.
- `level_cnt`  out  3  foods eaten in the current level.

## Operation
- **Reset.** Values after reset:
  - state=MAIN_START
  - score=0, level_cnt=0, snake_clock=0
  - poisoning=0, move_tick=0
  - all internal counters cleared
  - Reset asserted in any state, including mid-game, has this same result on the next edge.
- **MAIN_START.** `btn_start` moves to MAIN_WAIT and clears score, level_cnt, poisoning and snake_clock.
- **MAIN_WAIT.** The wait counter counts up to WAIT_CYCLES-1, then the block enters MAIN_GAME1. `btn_start` and all event inputs are ignored.
- **MAIN_GAMEn.** These are the only states where event inputs are honoured.
  - `collision` moves to MAIN_LOSE and has priority over every other event in the same cycle; those other events are dropped.
  - `food_eaten`: score+1 and level_cnt+1.
    - If level_cnt was LEVEL_FOOD-1, level_cnt becomes 0 and the state advances GAME1→GAME2→GAME3→MAIN_WIN.
    - The step counter resets on every level change.
  - `flash_eaten`: score+2. It does not affect level_cnt.
  - Simultaneous `food_eaten` and `flash_eaten`: score+3, and the level rule still applies.
  - `virus_hit`: poisoning goes to 1 and the poison counter loads POISON_CYCLES. A retrigger while already poisoned reloads the counter.
  - Poison expiry: when the poison counter reaches 1 it drops poisoning to 0.
- **Score arithmetic.** Score is 10-bit and saturates at 999; it never wraps.
- **move_tick period.** The period is STEPn for the current level. It is doubled (2·STEPn) while poisoning=1. The step counter is not reset when poisoning changes; the compare limit switches on the next cycle.
- **snake_clock.** Increments by 1 every cycle in MAIN_GAME1..3 and wraps modulo 2^32. It holds in every other state and clears on entry to MAIN_WAIT.
- **MAIN_WIN / MAIN_LOSE.** All outputs except state hold their values. Poisoning is forced to 0. `btn_start` returns the block to MAIN_START; score is kept until the next WAIT entry.

## Timing
- Every output is a register. An event sampled at edge k is visible at outputs after edge k, with one cycle of latency.
- `move_tick`:
  - First pulse comes exactly STEPn cycles after the edge that entered MAIN_GAMEn, then every STEPn cycles (2·STEPn when poisoned).
  - The pulse is exactly 1 cycle wide and never asserts outside GAME states.
  - No tick is emitted on the cycle that leaves a GAME state.
- MAIN_WAIT lasts exactly WAIT_CYCLES cycles.
- Poisoning stays high for exactly POISON_CYCLES cycles after the last `virus_hit`, unless the game leaves GAME states first.

## Test plan
- Sim parameters: WAIT_CYCLES=4, STEP1=8, STEP2=6, STEP3=4, LEVEL_FOOD=2, POISON_CYCLES=10.
- **Reset and start:** reset, then `btn_start` pulse → state=1 the next cycle, state=2 exactly 4 cycles later, first `move_tick` 8 cycles after that and every 8 cycles thereafter.
- **Level progression:** 6 `food_eaten` pulses spaced 3 cycles apart → state goes 2→3→4→5, score=6, level_cnt=0; the step counter restarts at each level change (tick gap 6, then 4).
- **Collision priority:** `collision`, `food_eaten` and `flash_eaten` in the same cycle with score=3 → state=6, score stays 3; `btn_start` → state=0.
- **Poison window:** `virus_hit` in GAME1 → poisoning=1 for 10 cycles and tick period 16; a retrigger at cycle 7 extends the window to 17 cycles total.
- **Score saturation:** score preloaded to 998, then `flash_eaten` → 999; then `food_eaten` → 999.
- **Reset mid-game:** in GAME2, poisoned, snake_clock=500, assert reset → state=0 and all outputs 0 on the next edge; event pulses during MAIN_WAIT change nothing.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Snake game sequencer: owns the main state bus, scoring, move tick, poison window
// and play-time counter. Every output is a register on clk_crystal.
module game_state_ctrl #(
    parameter int unsigned WAIT_CYCLES   = 50_000_000,
    parameter int unsigned STEP1         = 25_000_000,
    parameter int unsigned STEP2         = 15_000_000,
    parameter int unsigned STEP3         = 8_000_000,
    parameter int unsigned LEVEL_FOOD    = 5,
    parameter int unsigned POISON_CYCLES = 200_000_000
) (
    input  logic        clk_crystal,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        food_eaten,
    input  logic        flash_eaten,
    input  logic        virus_hit,
    input  logic        collision,
    output logic [2:0]  state,
    output logic        move_tick,
    output logic        poisoning,
    output logic [31:0] snake_clock,
    output logic [9:0]  score,
    output logic [2:0]  level_cnt
);

    typedef enum logic [2:0] {
        MAIN_START = 3'd0,
        MAIN_WAIT  = 3'd1,
        MAIN_GAME1 = 3'd2,
        MAIN_GAME2 = 3'd3,
        MAIN_GAME3 = 3'd4,
        MAIN_WIN   = 3'd5,
        MAIN_LOSE  = 3'd6
    } state_t;

    localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYCLES - 1);
    localparam logic [2:0]  LEVEL_LAST = 3'(LEVEL_FOOD - 1);
    localparam logic [31:0] POISON_LD  = 32'(POISON_CYCLES);

    state_t      state_q, state_nxt;
    logic [31:0] wait_cnt, wait_nxt;
    logic [31:0] step_cnt, step_nxt;
    logic [31:0] pois_cnt, pois_cnt_nxt;
    logic [31:0] clock_nxt;
    logic [9:0]  score_nxt;
    logic [2:0]  level_nxt;
    logic        tick_nxt, pois_nxt;
    logic [31:0] step_base, step_lim;
    logic [10:0] score_sum;

    assign state = state_q;

    // Limit follows the registered poisoning flag, so a change applies one cycle later.
    always_comb begin
        step_base = 32'(STEP1);
        case (state_q)
            MAIN_GAME2: step_base = 32'(STEP2);
            MAIN_GAME3: step_base = 32'(STEP3);
            default:    step_base = 32'(STEP1);
        endcase
        step_lim  = poisoning ? (step_base << 1) : step_base;
        score_sum = {1'b0, score} + 11'(food_eaten) + {9'd0, flash_eaten, 1'b0};
    end

    always_ff @(posedge clk_crystal) begin
        if (reset) begin
            state_q     <= MAIN_START;
            wait_cnt    <= '0;
            step_cnt    <= '0;
            pois_cnt    <= '0;
            snake_clock <= '0;
            score       <= '0;
            level_cnt   <= '0;
            move_tick   <= 1'b0;
            poisoning   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            wait_cnt    <= wait_nxt;
            step_cnt    <= step_nxt;
            pois_cnt    <= pois_cnt_nxt;
            snake_clock <= clock_nxt;
            score       <= score_nxt;
            level_cnt   <= level_nxt;
            move_tick   <= tick_nxt;
            poisoning   <= pois_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        wait_nxt     = wait_cnt;
        step_nxt     = step_cnt;
        pois_cnt_nxt = pois_cnt;
        clock_nxt    = snake_clock;
        score_nxt    = score;
        level_nxt    = level_cnt;
        tick_nxt     = 1'b0;
        pois_nxt     = poisoning;

        case (state_q)
            MAIN_START: begin
                if (btn_start) begin
                    state_nxt    = MAIN_WAIT;
                    wait_nxt     = '0;
                    step_nxt     = '0;
                    pois_cnt_nxt = '0;
                    clock_nxt    = '0;
                    score_nxt    = '0;
                    level_nxt    = '0;
                    pois_nxt     = 1'b0;
                end
            end
            MAIN_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = MAIN_GAME1;
                    wait_nxt  = '0;
                    step_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + 32'd1;
                end
            end
            MAIN_GAME1, MAIN_GAME2, MAIN_GAME3: begin
                clock_nxt = snake_clock + 32'd1;
                if (collision) begin
                    state_nxt    = MAIN_LOSE;
                    pois_nxt     = 1'b0;
                    pois_cnt_nxt = '0;
                end else begin
                    score_nxt = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
                    if (food_eaten && level_cnt == LEVEL_LAST) begin
                        level_nxt = '0;
                        step_nxt  = '0;
                        case (state_q)
                            MAIN_GAME1: state_nxt = MAIN_GAME2;
                            MAIN_GAME2: state_nxt = MAIN_GAME3;
                            default:    state_nxt = MAIN_WIN;
                        endcase
                    end else begin
                        if (food_eaten) level_nxt = level_cnt + 3'd1;
                        if (step_cnt >= step_lim - 32'd1) begin
                            tick_nxt = 1'b1;
                            step_nxt = '0;
                        end else begin
                            step_nxt = step_cnt + 32'd1;
                        end
                    end
                    if (virus_hit) begin
                        pois_nxt     = 1'b1;
                        pois_cnt_nxt = POISON_LD;
                    end else if (poisoning) begin
                        if (pois_cnt == 32'd1) begin
                            pois_nxt     = 1'b0;
                            pois_cnt_nxt = '0;
                        end else begin
                            pois_cnt_nxt = pois_cnt - 32'd1;
                        end
                    end
                    if (state_nxt == MAIN_WIN) begin
                        pois_nxt     = 1'b0;
                        pois_cnt_nxt = '0;
                    end
                end
            end
            MAIN_WIN, MAIN_LOSE: begin
                pois_nxt     = 1'b0;
                pois_cnt_nxt = '0;
                if (btn_start) state_nxt = MAIN_START;
            end
            default: state_nxt = MAIN_START;
        endcase
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: vector table, directed corner sequences,
// then random stimulus against an elapsed-time reference model.
module tb_game_state_ctrl;
    localparam int W = 4, S1 = 8, S2 = 6, S3 = 4, LF = 2, P = 10;

    logic        clk_crystal = 1'b0;
    logic        reset = 1'b0, btn_start = 1'b0, food_eaten = 1'b0;
    logic        flash_eaten = 1'b0, virus_hit = 1'b0, collision = 1'b0;
    logic [2:0]  state;
    logic        move_tick, poisoning;
    logic [31:0] snake_clock;
    logic [9:0]  score;
    logic [2:0]  level_cnt;

    int checks = 0;
    int passed = 0;

    game_state_ctrl #(
        .WAIT_CYCLES(W), .STEP1(S1), .STEP2(S2), .STEP3(S3),
        .LEVEL_FOOD(LF), .POISON_CYCLES(P)
    ) dut (
        .clk_crystal(clk_crystal), .reset(reset), .btn_start(btn_start),
        .food_eaten(food_eaten), .flash_eaten(flash_eaten), .virus_hit(virus_hit),
        .collision(collision), .state(state), .move_tick(move_tick),
        .poisoning(poisoning), .snake_clock(snake_clock), .score(score),
        .level_cnt(level_cnt)
    );

    always #5 clk_crystal = ~clk_crystal;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_crystal);
        #1;
    endtask

    task automatic clear_in();
        reset = 0; btn_start = 0; food_eaten = 0; flash_eaten = 0; virus_hit = 0; collision = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1; step(); reset = 0;
    endtask

    task automatic start_game();
        int n = 0;
        btn_start = 1; step(); btn_start = 0;
        while (state != 3'd2 && n < 50) begin step(); n++; end
        check("start_game_reaches_game1", state, 2);
    endtask

    task automatic wait_tick(output int gap);
        gap = 0;
        do begin step(); gap++; end while (!move_tick && gap < 100);
    endtask

    task automatic feed_level();
        food_eaten = 1; step(); food_eaten = 0; step(); step();
        food_eaten = 1; step(); food_eaten = 0;
    endtask

    typedef struct {
        logic rst, btn, food, flash, virus, coll;
        int   st, sc, lv;
        logic tk, ps;
    } vec_t;
    vec_t vecs[19];

    function automatic vec_t mk(logic r, b, f, fl, v, c, int st, sc, lv, logic tk, ps);
        vec_t x;
        x.rst = r; x.btn = b; x.food = f; x.flash = fl; x.virus = v; x.coll = c;
        x.st = st; x.sc = sc; x.lv = lv; x.tk = tk; x.ps = ps;
        return x;
    endfunction

    // Reference model: tick and poison derived from absolute edge times.
    int     m_state, m_score, m_level;
    logic [31:0] m_clk;
    bit     m_tick, m_pois;
    longint n_edge, m_wait_start, m_last_ref, m_pois_until;

    task automatic model_edge(input bit r, b, f, fl, v, c);
        int  steplen;
        bit  pre_pois;
        pre_pois = m_pois;
        n_edge++;
        m_tick = 0;
        if (r) begin
            m_state = 0; m_score = 0; m_level = 0; m_clk = 0; m_pois = 0;
            return;
        end
        case (m_state)
            0: if (b) begin
                m_state = 1; m_score = 0; m_level = 0; m_pois = 0; m_clk = 0;
                m_wait_start = n_edge;
            end
            1: if (n_edge - m_wait_start == W) begin
                m_state = 2; m_last_ref = n_edge;
            end
            2, 3, 4: begin
                m_clk = m_clk + 1;
                if (c) begin
                    m_state = 6; m_pois = 0;
                end else begin
                    steplen = (m_state == 2) ? S1 : (m_state == 3) ? S2 : S3;
                    if (pre_pois) steplen = steplen * 2;
                    m_score = (m_score + f + 2 * fl > 999) ? 999 : m_score + f + 2 * fl;
                    if (f && m_level == LF - 1) begin
                        m_level = 0; m_state = m_state + 1; m_last_ref = n_edge;
                    end else begin
                        if (f) m_level++;
                        if (n_edge - m_last_ref >= steplen) begin
                            m_tick = 1; m_last_ref = n_edge;
                        end
                    end
                    if (v) m_pois_until = n_edge + P;
                    m_pois = v || (pre_pois && n_edge < m_pois_until);
                    if (m_state == 5) m_pois = 0;
                end
            end
            default: begin
                m_pois = 0;
                if (b) m_state = 0;
            end
        endcase
    endtask

    initial begin
        int gap, cnt, t_last;
        longint ticks[$];
        logic [31:0] held_clk;
        bit r, b, f, fl, v, c;

        // Vector table: start, ignored events in WAIT, scoring, first tick, collision priority.
        vecs[0]  = mk(1,0,0,0,0,0, 0,0,0, 0,0);
        vecs[1]  = mk(0,1,0,0,0,0, 1,0,0, 0,0);
        vecs[2]  = mk(0,0,1,0,0,0, 1,0,0, 0,0);
        vecs[3]  = mk(0,0,0,0,1,0, 1,0,0, 0,0);
        vecs[4]  = mk(0,1,0,0,0,0, 1,0,0, 0,0);
        vecs[5]  = mk(0,0,0,0,0,0, 2,0,0, 0,0);
        vecs[6]  = mk(0,0,1,0,0,0, 2,1,1, 0,0);
        vecs[7]  = mk(0,0,0,1,0,0, 2,3,1, 0,0);
        vecs[8]  = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[9]  = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[10] = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[11] = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[12] = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[13] = mk(0,0,0,0,0,0, 2,3,1, 1,0);
        vecs[14] = mk(0,0,0,0,0,0, 2,3,1, 0,0);
        vecs[15] = mk(0,0,1,1,0,1, 6,3,1, 0,0);
        vecs[16] = mk(0,0,1,0,0,0, 6,3,1, 0,0);
        vecs[17] = mk(0,1,0,0,0,0, 0,3,1, 0,0);
        vecs[18] = mk(0,0,0,0,0,0, 0,3,1, 0,0);

        clear_in();
        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst; btn_start = vecs[i].btn; food_eaten = vecs[i].food;
            flash_eaten = vecs[i].flash; virus_hit = vecs[i].virus; collision = vecs[i].coll;
            step();
            check($sformatf("vec%0d.state", i), state, vecs[i].st);
            check($sformatf("vec%0d.score", i), score, vecs[i].sc);
            check($sformatf("vec%0d.level", i), level_cnt, vecs[i].lv);
            check($sformatf("vec%0d.tick", i), move_tick, vecs[i].tk);
            check($sformatf("vec%0d.poison", i), poisoning, vecs[i].ps);
        end
        clear_in();

        // Start timing and level progression.
        do_reset();
        check("reset_clock", snake_clock, 0);
        btn_start = 1; step(); btn_start = 0;
        check("wait_entry", state, 1);
        cnt = 0;
        while (state == 3'd1 && cnt < 50) begin step(); cnt++; end
        check("wait_len", cnt, W);
        check("game1_entry_clock", snake_clock, 0);
        wait_tick(gap); check("g1_first_tick", gap, S1);
        check("g1_clock_at_tick", snake_clock, S1);
        wait_tick(gap); check("g1_second_tick", gap, S1);
        feed_level();
        check("g2_state", state, 3); check("g2_level", level_cnt, 0); check("g2_score", score, 2);
        wait_tick(gap); check("g2_first_tick", gap, S2);
        wait_tick(gap); check("g2_second_tick", gap, S2);
        feed_level();
        check("g3_state", state, 4);
        wait_tick(gap); check("g3_first_tick", gap, S3);
        wait_tick(gap); check("g3_second_tick", gap, S3);
        feed_level();
        check("win_state", state, 5); check("win_score", score, 6);
        check("win_level", level_cnt, 0); check("win_tick", move_tick, 0);
        held_clk = snake_clock;
        step(); step(); step();
        check("win_clock_hold", snake_clock, held_clk);
        check("win_score_hold", score, 6);
        btn_start = 1; step(); btn_start = 0;
        check("win_to_start", state, 0);

        // Poison window, retrigger and doubled tick period.
        do_reset();
        start_game();
        virus_hit = 1; step(); virus_hit = 0;
        cnt = 0;
        while (poisoning && cnt < 100) begin cnt++; step(); end
        check("poison_len", cnt, P);
        virus_hit = 1; step(); virus_hit = 0;
        cnt = 0;
        while (poisoning && cnt < 100) begin
            cnt++;
            virus_hit = (cnt == 7);
            step();
        end
        virus_hit = 0;
        check("poison_retrigger_len", cnt, 17);
        t_last = 0;
        for (int i = 0; i < 80; i++) begin
            virus_hit = (i % 5 == 0);
            step();
            if (move_tick) ticks.push_back(i);
        end
        virus_hit = 0;
        if (ticks.size() >= 3) check("poison_tick_period", ticks[ticks.size()-1] - ticks[ticks.size()-2], 2 * S1);
        else check("poison_tick_count", ticks.size(), 3);

        // Score saturation.
        do_reset();
        start_game();
        flash_eaten = 1;
        repeat (499) step();
        flash_eaten = 0;
        check("score_998", score, 998);
        flash_eaten = 1; step(); flash_eaten = 0;
        check("score_sat_flash", score, 999);
        food_eaten = 1; step(); food_eaten = 0;
        check("score_sat_food", score, 999);
        check("sat_food_level", level_cnt, 1);

        // Reset mid-game while poisoned, then events ignored during WAIT.
        do_reset();
        start_game();
        feed_level();
        check("mid_game2", state, 3);
        virus_hit = 1;
        cnt = 0;
        while (snake_clock != 32'd500 && cnt < 1000) begin step(); cnt++; end
        check("mid_clock", snake_clock, 500);
        check("mid_poison", poisoning, 1);
        reset = 1; step(); reset = 0; virus_hit = 0;
        check("mid_rst_state", state, 0); check("mid_rst_score", score, 0);
        check("mid_rst_level", level_cnt, 0); check("mid_rst_tick", move_tick, 0);
        check("mid_rst_poison", poisoning, 0); check("mid_rst_clock", snake_clock, 0);
        btn_start = 1; step();
        food_eaten = 1; flash_eaten = 1; virus_hit = 1; collision = 1;
        repeat (W - 1) step();
        clear_in();
        step();
        check("wait_ignore_state", state, 2); check("wait_ignore_score", score, 0);
        check("wait_ignore_poison", poisoning, 0); check("wait_ignore_level", level_cnt, 0);

        // Random stimulus against the reference model.
        n_edge = 0;
        reset = 1; step(); model_edge(1, 0, 0, 0, 0, 0); reset = 0;
        for (int i = 0; i < 6000; i++) begin
            r  = ($urandom_range(1499) == 0);
            b  = ($urandom_range(7) == 0);
            f  = ($urandom_range(5) == 0);
            fl = ($urandom_range(11) == 0);
            v  = ($urandom_range(24) == 0);
            c  = ($urandom_range(149) == 0);
            reset = r; btn_start = b; food_eaten = f; flash_eaten = fl; virus_hit = v; collision = c;
            step();
            model_edge(r, b, f, fl, v, c);
            checks++;
            if (state == m_state && score == m_score && level_cnt == m_level &&
                move_tick == m_tick && poisoning == m_pois && snake_clock == m_clk)
                passed++;
            else
                $display("FAIL rand%0d: got st=%0d sc=%0d lv=%0d tk=%0d ps=%0d clk=%0d expected st=%0d sc=%0d lv=%0d tk=%0d ps=%0d clk=%0d",
                         i, state, score, level_cnt, move_tick, poisoning, snake_clock,
                         m_state, m_score, m_level, m_tick, m_pois, m_clk);
        end
        clear_in();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
